// File: rtl/pen_hit_detector_pkg.sv
// Shared state encodings, position record and default parameters for the
// light-pen hit detector.
package pen_hit_detector_pkg;

  localparam int PEN_SYNC_STAGES = 2;
  localparam int PEN_MIN_HIGH    = 4;
  localparam int PEN_LAT_COMP    = 3;
  localparam int PEN_HIST_DEPTH  = 8;
  localparam int PEN_RELEASE_CYC = 16;

  typedef enum logic [1:0] {
    PEN_IDLE    = 2'd0,
    PEN_QUALIFY = 2'd1,
    PEN_EMIT    = 2'd2,
    PEN_HOLDOFF = 2'd3
  } pen_state_e;

  // One scan-history entry: ok is set only when row and column are both one-hot.
  typedef struct packed {
    logic       ok;
    logic [2:0] row;
    logic [2:0] col;
  } pen_pos_t;

  function automatic logic pen_pos_equal(input pen_pos_t a, input pen_pos_t b);
    return a == b;
  endfunction

endpackage

// File: rtl/pen_hit_detector_onehot_enc8.sv
// 8-bit one-hot to 3-bit index encoder; o_ok is high only when exactly one
// input bit is set (blanking and multi-hot codes report o_ok=0).
module onehot_enc8 (
  input  logic [7:0] i_onehot,
  output logic [2:0] o_idx,
  output logic       o_ok
);

  logic [2:0] w_idx;
  logic [3:0] w_cnt;

  always_comb begin
    w_idx = '0;
    w_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      if (i_onehot[i]) begin
        w_idx = w_idx | 3'(i);
        w_cnt = w_cnt + 4'd1;
      end
    end
  end

  assign o_idx = w_idx;
  assign o_ok  = (w_cnt == 4'd1);

endmodule

// File: rtl/pen_hit_detector.sv
// Light-pen hit detector: synchronizes the photodiode, looks back into the
// scan history to undo optical latency, qualifies the pulse and strobes we.
module pen_hit_detector
  import pen_hit_detector_pkg::*;
#(
  parameter int SYNC_STAGES = PEN_SYNC_STAGES,
  parameter int MIN_HIGH    = PEN_MIN_HIGH,
  parameter int LAT_COMP    = PEN_LAT_COMP,
  parameter int HIST_DEPTH  = PEN_HIST_DEPTH,
  parameter int RELEASE_CYC = PEN_RELEASE_CYC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pen_in,
  input  logic [7:0] led_row,
  input  logic [7:0] led_col,
  output logic       we,
  output logic [2:0] hit_row,
  output logic [2:0] hit_col,
  output logic       pen_active
);

  localparam int QCNT_W = $clog2(MIN_HIGH + 1);
  localparam int RCNT_W = $clog2(RELEASE_CYC + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("pen_hit_detector: SYNC_STAGES must be >= 2");
  end
  if (MIN_HIGH < 1) begin : g_bad_min_high
    $error("pen_hit_detector: MIN_HIGH must be >= 1");
  end
  if (HIST_DEPTH < 2) begin : g_bad_depth
    $error("pen_hit_detector: HIST_DEPTH must be >= 2");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_pen_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], pen_in};
  end

  assign w_pen_s = r_sync[SYNC_STAGES-1];

  logic [2:0] w_row_idx;
  logic [2:0] w_col_idx;
  logic       w_row_ok;
  logic       w_col_ok;
  pen_pos_t   w_cur;

  onehot_enc8 u_row_enc (
    .i_onehot (led_row),
    .o_idx    (w_row_idx),
    .o_ok     (w_row_ok)
  );

  onehot_enc8 u_col_enc (
    .i_onehot (led_col),
    .o_idx    (w_col_idx),
    .o_ok     (w_col_ok)
  );

  assign w_cur = {w_row_ok & w_col_ok, w_row_idx, w_col_idx};

  // r_hist[k] is the position k cycles old; the current position is entry 0.
  pen_pos_t r_hist [1:HIST_DEPTH-1];
  pen_pos_t w_tap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < HIST_DEPTH; k++) r_hist[k] <= '0;
    end else begin
      r_hist[1] <= w_cur;
      for (int k = 2; k < HIST_DEPTH; k++) r_hist[k] <= r_hist[k-1];
    end
  end

  if (LAT_COMP == 0) begin : g_tap_now
    assign w_tap = w_cur;
  end else if (LAT_COMP < HIST_DEPTH) begin : g_tap_hist
    assign w_tap = r_hist[LAT_COMP];
  end else begin : g_bad_lat
    $error("pen_hit_detector: LAT_COMP must be < HIST_DEPTH");
    assign w_tap = '0;
  end

  // Repeat-suppression release timer: reloads while the pen sees light and
  // counts down through dark cycles; the 1->0 step drops the last-hit memory.
  logic [RCNT_W-1:0] r_rel_cnt;
  logic              w_release;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_rel_cnt <= '0;
    else if (w_pen_s)         r_rel_cnt <= RCNT_W'(RELEASE_CYC);
    else if (r_rel_cnt != '0) r_rel_cnt <= r_rel_cnt - RCNT_W'(1);
  end

  assign w_release = !w_pen_s && (r_rel_cnt == RCNT_W'(1));

  pen_state_e        r_state;
  pen_state_e        w_state_nxt;
  logic [QCNT_W-1:0] r_qcnt;
  logic [QCNT_W-1:0] w_qcnt_nxt;
  pen_pos_t          r_cand;
  pen_pos_t          w_cand_nxt;
  pen_pos_t          r_last;
  logic              r_last_valid;
  logic              w_fresh;
  logic              w_we;
  logic [2:0]        r_hit_row;
  logic [2:0]        r_hit_col;

  assign w_fresh = r_cand.ok && !(r_last_valid && pen_pos_equal(r_cand, r_last));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= PEN_IDLE;
      r_qcnt  <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    w_cand_nxt  = r_cand;
    w_we        = 1'b0;
    case (r_state)
      PEN_IDLE: begin
        w_qcnt_nxt = '0;
        if (w_pen_s) begin
          w_state_nxt = PEN_QUALIFY;
          w_qcnt_nxt  = QCNT_W'(1);
          w_cand_nxt  = w_tap;
        end
      end
      PEN_QUALIFY: begin
        // The IDLE cycle counted the first high sample, so the decision is
        // taken once MIN_HIGH samples have been seen, whatever pen_s does now.
        if (r_qcnt == QCNT_W'(MIN_HIGH)) begin
          w_state_nxt = w_fresh ? PEN_EMIT : PEN_HOLDOFF;
        end else if (w_pen_s) begin
          w_qcnt_nxt = r_qcnt + QCNT_W'(1);
        end else begin
          w_state_nxt = PEN_IDLE;
        end
      end
      PEN_EMIT: begin
        w_we        = 1'b1;
        w_state_nxt = PEN_HOLDOFF;
      end
      PEN_HOLDOFF: begin
        if (!w_pen_s) w_state_nxt = PEN_IDLE;
      end
      default: w_state_nxt = PEN_IDLE;
    endcase
    if (!en) begin
      w_state_nxt = PEN_IDLE;
      w_we        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last       <= '0;
      r_last_valid <= 1'b0;
      r_hit_row    <= '0;
      r_hit_col    <= '0;
    end else if (w_we) begin
      r_last       <= r_cand;
      r_last_valid <= 1'b1;
      r_hit_row    <= r_cand.row;
      r_hit_col    <= r_cand.col;
    end else if (w_release) begin
      r_last_valid <= 1'b0;
    end
  end

  // The tag is presented in the strobe cycle itself and held afterwards.
  assign we         = w_we;
  assign hit_row    = w_we ? r_cand.row : r_hit_row;
  assign hit_col    = w_we ? r_cand.col : r_hit_col;
  assign pen_active = w_pen_s;

endmodule

// File: tb/tb_pen_hit_detector.sv
// Randomized and directed scenarios for pen_hit_detector, each started from
// reset and compared cycle by cycle against an offline window-based model.
module tb_pen_hit_detector;

  localparam int SYNC = 2;
  localparam int MH   = 4;
  localparam int LAT  = 3;
  localparam int HD   = 8;
  localparam int REL  = 16;
  localparam int MAXL = 256;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       pen_in = 1'b1;
  logic [7:0] led_row = 8'h00;
  logic [7:0] led_col = 8'h00;
  logic       we;
  logic [2:0] hit_row;
  logic [2:0] hit_col;
  logic       pen_active;

  pen_hit_detector #(
    .SYNC_STAGES (SYNC),
    .MIN_HIGH    (MH),
    .LAT_COMP    (LAT),
    .HIST_DEPTH  (HD),
    .RELEASE_CYC (REL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pen_in     (pen_in),
    .led_row    (led_row),
    .led_col    (led_col),
    .we         (we),
    .hit_row    (hit_row),
    .hit_col    (hit_col),
    .pen_active (pen_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int L = 0;

  logic       a_pen [MAXL];
  logic       a_en  [MAXL];
  logic [7:0] a_row [MAXL];
  logic [7:0] a_col [MAXL];

  logic       x_ps  [MAXL];
  logic       x_we  [MAXL];
  logic [2:0] x_row [MAXL];
  logic [2:0] x_col [MAXL];
  int         lr    [MAXL];
  logic       ev_we [MAXL];
  int         ev_r  [MAXL];
  int         ev_c  [MAXL];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] oh(input int i);
    logic [7:0] v;
    v = 8'h01;
    return v << i;
  endfunction

  function automatic int ps_at(input int i);
    return (i >= 0 && i < L) ? int'(x_ps[i]) : 0;
  endfunction

  function automatic int en_at(input int i);
    return (i >= 0 && i < L) ? int'(a_en[i]) : 0;
  endfunction

  task automatic clear_stim(input int len);
    L = len;
    for (int i = 0; i < MAXL; i++) begin
      a_pen[i] = 1'b0;
      a_en[i]  = 1'b1;
      a_row[i] = oh(0);
      a_col[i] = oh(0);
    end
  endtask

  task automatic set_pen(input int a, input int b, input logic v);
    for (int i = a; i <= b && i < L; i++) a_pen[i] = v;
  endtask

  task automatic set_en(input int a, input int b, input logic v);
    for (int i = a; i <= b && i < L; i++) a_en[i] = v;
  endtask

  task automatic set_pos(input int a, input int b, input logic [7:0] r, input logic [7:0] c);
    for (int i = a; i <= b && i < L; i++) begin
      a_row[i] = r;
      a_col[i] = c;
    end
  endtask

  // Works on whole presses: find where pen_s is accepted, look ahead through
  // the qualification window, then decide strobe and when detection re-arms.
  task automatic build_expect();
    int free, lv, last_r, last_c, cur_r, cur_c;
    for (int n = 0; n < L; n++) begin
      x_ps[n]  = (n >= SYNC) ? a_pen[n-SYNC] : 1'b0;
      lr[n]    = x_ps[n] ? 0 : ((n == 0) ? 1 : lr[n-1] + 1);
      ev_we[n] = 1'b0;
      ev_r[n]  = 0;
      ev_c[n]  = 0;
    end
    free = 0; lv = 0; last_r = 0; last_c = 0; cur_r = 0; cur_c = 0;
    for (int n = 0; n < L; n++) begin
      if (n > 0) begin
        if (ev_we[n-1]) begin
          lv = 1; last_r = ev_r[n-1]; last_c = ev_c[n-1];
        end
        if (lr[n-1] == REL) lv = 0;
      end
      if (n >= free && a_en[n] && x_ps[n]) begin
        int  fail, e, ci, h, cr, cc;
        bit  cok, emit;
        fail = 0;
        for (int j = 1; j <= MH; j++)
          if (fail == 0 && (en_at(n+j) == 0 || (j < MH && ps_at(n+j) == 0))) fail = j;
        if (fail != 0) begin
          free = n + fail + 1;
        end else begin
          e    = n + MH + 1;
          ci   = n - LAT;
          cok  = (ci >= 0) && $onehot(a_row[ci]) && $onehot(a_col[ci]);
          cr   = cok ? $clog2(a_row[ci]) : 0;
          cc   = cok ? $clog2(a_col[ci]) : 0;
          emit = cok && !(lv == 1 && cr == last_r && cc == last_c);
          if (emit && en_at(e) == 0) begin
            free = e + 1;
          end else begin
            if (emit) begin
              if (e < L) begin
                ev_we[e] = 1'b1; ev_r[e] = cr; ev_c[e] = cc;
              end
              h = e + 1;
            end else begin
              h = e;
            end
            while (ps_at(h) != 0 && en_at(h) != 0) h++;
            free = h + 1;
          end
        end
      end
      if (ev_we[n]) begin
        cur_r = ev_r[n]; cur_c = ev_c[n];
      end
      x_we[n]  = ev_we[n];
      x_row[n] = 3'(cur_r);
      x_col[n] = 3'(cur_c);
    end
  endtask

  task automatic drive(input int n);
    pen_in  = a_pen[n];
    en      = a_en[n];
    led_row = a_row[n];
    led_col = a_col[n];
  endtask

  task automatic run_scenario(input string name);
    build_expect();
    rst = 1'b1; pen_in = 1'b1; en = 1'b1; led_row = oh(2); led_col = oh(5);
    repeat (2) begin
      @(negedge clk);
      check_eq($sformatf("%s rst we", name), int'(we), 0);
      check_eq($sformatf("%s rst hit_row", name), int'(hit_row), 0);
      check_eq($sformatf("%s rst hit_col", name), int'(hit_col), 0);
      check_eq($sformatf("%s rst pen_active", name), int'(pen_active), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0);
    for (int n = 0; n < L; n++) begin
      @(negedge clk);
      check_eq($sformatf("%s we @%0d", name, n), int'(we), int'(x_we[n]));
      check_eq($sformatf("%s hit_row @%0d", name, n), int'(hit_row), int'(x_row[n]));
      check_eq($sformatf("%s hit_col @%0d", name, n), int'(hit_col), int'(x_col[n]));
      check_eq($sformatf("%s pen_active @%0d", name, n), int'(pen_active), int'(x_ps[n]));
      if (n < L - 1) begin
        @(posedge clk);
        #1;
        drive(n + 1);
      end
    end
  endtask

  task automatic gen_random(input int len);
    int n, run, k;
    logic [7:0] r, c;
    clear_stim(len);
    n = 0;
    while (n < len) begin
      n  += $urandom_range(1, 24);
      run = $urandom_range(1, 8);
      set_pen(n, n + run - 1, 1'b1);
      n  += run;
    end
    n = 0;
    while (n < len) begin
      run = $urandom_range(1, 6);
      k   = $urandom_range(0, 9);
      r   = oh($urandom_range(0, 7));
      c   = oh($urandom_range(0, 7));
      if (k < 4) begin
        r = oh(4); c = oh(4);
      end else if (k == 4) begin
        r = 8'h00;
      end else if (k == 5) begin
        r = 8'h18;
      end
      set_pos(n, n + run - 1, r, c);
      n += run;
    end
    for (int i = 0; i < len; i++) a_en[i] = ($urandom_range(0, 49) != 0);
  endtask

  initial begin
    // pen held high through reset: history is invalid at the cand sample.
    clear_stim(24);
    set_pos(0, 23, oh(2), oh(5));
    set_pen(0, 12, 1'b1);
    run_scenario("reset");

    clear_stim(40);
    set_pos(0, 39, oh(2), oh(5));
    set_pen(10, 15, 1'b1);
    run_scenario("clean");

    clear_stim(60);
    set_pos(0, 59, oh(2), oh(5));
    set_pen(10, 12, 1'b1);
    set_pen(30, 33, 1'b1);
    run_scenario("glitch");

    clear_stim(100);
    set_pos(0, 69, oh(4), oh(4));
    set_pos(70, 99, oh(4), oh(5));
    set_pen(10, 15, 1'b1);
    set_pen(26, 31, 1'b1);
    set_pen(52, 57, 1'b1);
    set_pen(62, 67, 1'b1);
    set_pen(74, 79, 1'b1);
    run_scenario("repeat");

    clear_stim(40);
    set_pos(0, 39, oh(2), oh(5));
    a_row[9] = 8'h00;
    set_pen(10, 17, 1'b1);
    run_scenario("blank");

    clear_stim(50);
    set_pos(0, 49, oh(3), oh(1));
    set_pen(10, 20, 1'b1);
    set_en(14, 25, 1'b0);
    run_scenario("en_drop");

    // Ends while the FSM is qualifying; the next scenario's reset aborts it.
    clear_stim(13);
    set_pos(0, 12, oh(1), oh(6));
    set_pen(8, 12, 1'b1);
    run_scenario("rst_mid");

    clear_stim(60);
    for (int n = 0; n < 60; n++) begin
      a_row[n] = oh(((n + 54) % 64) / 8);
      a_col[n] = oh((n + 54) % 8);
    end
    set_pen(10, 16, 1'b1);
    run_scenario("wrap");

    for (int s = 0; s < 12; s++) begin
      gen_random(200);
      run_scenario($sformatf("rand%0d", s));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
